// File: rtl/ripple_carry_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ripple_carry_subtractor_pkg
// Brief   : Shared width constants for the ripple-carry subtractor.
// Revision: 1.0
// ============================================================================
package ripple_carry_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MIN_WIDTH     = 1;
  localparam int MAX_WIDTH     = 32;

endpackage : ripple_carry_subtractor_pkg
`default_nettype wire

// File: rtl/ripple_carry_subtractor_full_subtractor.sv
`default_nettype none
// ============================================================================
// Module  : full_subtractor
// Brief   : One-bit full subtractor stage (a - b - bi -> d, bo).
// Revision: 1.0
// ============================================================================
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  logic a_xor_b;

  assign a_xor_b = a ^ b;
  assign d       = a_xor_b ^ bi;
  assign bo      = (~a & b) | (~a_xor_b & bi);

endmodule : full_subtractor
`default_nettype wire

// File: rtl/ripple_carry_subtractor.sv
`default_nettype none
// ============================================================================
// Module  : ripple_carry_subtractor
// Brief   : Registered WIDTH-bit ripple-borrow subtractor, one result per cycle.
//           Define RIPPLE_CARRY_SUBTRACTOR_OVF_EN to add the signed overflow flag.
// Revision: 1.0
// ============================================================================
module ripple_carry_subtractor
  import ripple_carry_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             out_valid,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef RIPPLE_CARRY_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   borrow;
  logic [WIDTH-1:0] diff_next;

  if ((WIDTH < MIN_WIDTH) || (WIDTH > MAX_WIDTH)) begin : g_bad_width
    $error("ripple_carry_subtractor: WIDTH out of legal range");
  end

  assign borrow[0] = bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    full_subtractor u_fs (
      .a  (A[i]),
      .b  (B[i]),
      .bi (borrow[i]),
      .d  (diff_next[i]),
      .bo (borrow[i+1])
    );
  end

  // Result registers only load on valid input; out_valid tracks in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Diff      <= '0;
      Bout      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Diff <= diff_next;
        Bout <= borrow[WIDTH];
      end
    end
  end

`ifdef RIPPLE_CARRY_SUBTRACTOR_OVF_EN
  logic ovf_next;

  assign ovf_next = (A[WIDTH-1] != B[WIDTH-1]) && (diff_next[WIDTH-1] != A[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= ovf_next;
    end
  end
`endif

endmodule : ripple_carry_subtractor
`default_nettype wire

// File: tb/tb_ripple_carry_subtractor.sv
`default_nettype none
// ============================================================================
// Module  : tb_ripple_carry_subtractor
// Brief   : Scoreboard bench for ripple_carry_subtractor at WIDTH=4.
// Revision: 1.0
// ============================================================================
module tb_ripple_carry_subtractor;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic [W-1:0] Diff;
  logic         Bout;
`ifdef RIPPLE_CARRY_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q[$];

  ripple_carry_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .bin       (bin),
    .out_valid (out_valid),
    .Diff      (Diff),
    .Bout      (Bout)
`ifdef RIPPLE_CARRY_SUBTRACTOR_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] a_i, input logic [W-1:0] b_i, input logic bi_i);
    logic [W:0] full;
    exp_t       e;
    full   = {1'b0, a_i} - {1'b0, b_i} - {{W{1'b0}}, bi_i};
    e.diff = full[W-1:0];
    e.bout = full[W];
    e.ovf  = (a_i[W-1] != b_i[W-1]) && (full[W-1] != a_i[W-1]);
    A        = a_i;
    B        = b_i;
    bin      = bi_i;
    in_valid = 1'b1;
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Output monitor: every valid result must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("diff", 32'(Diff), 32'(e.diff));
        check("bout", 32'(Bout), 32'(e.bout));
`ifdef RIPPLE_CARRY_SUBTRACTOR_OVF_EN
        check("ovf", 32'(ovf), 32'(e.ovf));
`endif
      end
    end
  end

  initial begin
    // Reset state
    #3;
    check("rst_diff", 32'(Diff), 32'd0);
    check("rst_bout", 32'(Bout), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors
    send(4'b1101, 4'b1010, 1'b0);
    send(4'b1000, 4'b0111, 1'b0);
    send(4'b1111, 4'b0001, 1'b1);
    send(4'b0101, 4'b0011, 1'b0);
    send(4'b0011, 4'b0101, 1'b0);
    send(4'b0111, 4'b1000, 1'b0);
    // Boundaries
    send(4'b0110, 4'b0110, 1'b1);
    send(4'b0000, 4'b1111, 1'b1);
    send(4'b1111, 4'b0000, 1'b0);

    // Hold while idle
    send(4'b1101, 4'b1010, 1'b0);
    A = 4'b0001; B = 4'b1110; bin = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_diff", 32'(Diff), 32'b0011);
      check("hold_bout", 32'(Bout), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd0);
    end

    // Asynchronous reset mid-cycle after a valid result
    send(4'b1101, 4'b1010, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_diff", 32'(Diff), 32'd0);
    check("async_rst_bout", 32'(Bout), 32'd0);
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    A = 4'b1111; B = 4'b0000; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("rst_discard_diff", 32'(Diff), 32'd0);
    check("rst_discard_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(4'b1000, 4'b0111, 1'b0);

    // Exhaustive back-to-back sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          logic [31:0] av, bv, cv;
          av = a; bv = b; cv = c;
          send(av[W-1:0], bv[W-1:0], cv[0]);
        end
      end
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ripple_carry_subtractor
`default_nettype wire

// File: doc/ripple_carry_subtractor.md
RIPPLE_CARRY_SUBTRACTOR -- requirements
Module: ripple_carry_subtractor

Interface
REQ-001 Parameter: WIDTH, default 4, operand and difference width in bits (legal range 1..32).
REQ-002 One clock, clk; reset rst_n is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operands on A/B/bin are valid this cycle.
REQ-006 A  input  WIDTH  minuend, unsigned.
REQ-007 B  input  WIDTH  subtrahend, unsigned.
REQ-008 bin  input  1  borrow-in, subtracted from the least significant bit.
REQ-009 out_valid  output  1  Diff/Bout hold a new result this cycle.
REQ-010 Diff  output  WIDTH  registered difference.
REQ-011 Bout  output  1  registered borrow-out of the most significant stage.
REQ-012 ovf  output  1  registered two's-complement overflow; present only when RIPPLE_CARRY_SUBTRACTOR_OVF_EN is defined.

Function
REQ-013 Diff SHALL equal (A - B - bin) mod 2^WIDTH, computed as a chain of WIDTH full-subtractor stages.
REQ-014 Stage i: d = a^b^bi; bo = (~a & b) | (~(a^b) & bi); stage 0 bi = bin; stage i+1 bi = stage i bo.
REQ-015 Bout SHALL be 1 exactly when A < B + bin (unsigned), i.e. the final stage borrow.
REQ-016 Latency: result for operands sampled at a rising clk edge with in_valid=1 SHALL appear on Diff/Bout/out_valid after that same edge (1 cycle).
REQ-017 out_valid SHALL be a registered copy of in_valid; no backpressure, one result accepted every cycle.
REQ-018 When in_valid=0 at an edge, Diff, Bout and ovf SHALL hold their previous values; out_valid SHALL go 0.
REQ-019 Boundary: A=B, bin=1 -> Diff all ones, Bout=1; A=0, B=all ones, bin=1 -> Diff=0, Bout=1; A=all ones, B=0, bin=0 -> Diff all ones, Bout=0.
REQ-020 No internal state other than the output registers; back-to-back valid inputs SHALL produce back-to-back results.

Reset
REQ-021 rst_n low SHALL immediately force Diff=0, Bout=0, out_valid=0, ovf=0, independent of clk.
REQ-022 Reset asserted mid-stream SHALL discard any result not yet registered; first valid edge after release produces a normal result.
REQ-023 Reset release SHALL be synchronised by the system; the block itself contains no reset synchroniser.

Configuration
REQ-024 Macro RIPPLE_CARRY_SUBTRACTOR_OVF_EN: when defined, ovf port exists and is registered alongside Diff as (A[MSB] != B[MSB]) && (Diff_next[MSB] != A[MSB]), treating A, B as signed and ignoring bin in the sign test only via the computed Diff.
REQ-025 When RIPPLE_CARRY_SUBTRACTOR_OVF_EN is undefined, the ovf port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-026 Shared package ripple_carry_subtractor_pkg SHALL hold the default width constant (4) and the legal WIDTH range limits.
REQ-027 Sub-module full_subtractor (1-bit a, b, bi -> d, bo) SHALL implement REQ-014; the top instantiates WIDTH copies via generate.
REQ-028 The ripple chain SHALL be purely combinational between the input ports and the output registers; no pipeline stages inside the chain.

Verification
REQ-029 A=1101, B=1010, bin=0, in_valid=1 -> next cycle Diff=0011, Bout=0, out_valid=1.
REQ-030 A=1000, B=0111, bin=0 -> Diff=0001, Bout=0; then A=1111, B=0001, bin=1 -> Diff=1101, Bout=0.
REQ-031 A=0101, B=0011, bin=0 -> Diff=0010, Bout=0; A=0011, B=0101, bin=0 -> Diff=1110, Bout=1.
REQ-032 Assert rst_n=0 between clock edges after a valid result -> Diff=0000, Bout=0, out_valid=0 immediately.
REQ-033 in_valid=0 for 3 cycles after A=1101, B=1010 result -> Diff stays 0011, out_valid=0.
REQ-034 With RIPPLE_CARRY_SUBTRACTOR_OVF_EN: A=0111, B=1000, bin=0 -> Diff=1111, Bout=1, ovf=1; A=0101, B=0011 -> ovf=0; exhaustive 4-bit sweep vs. A-B-bin reference model.
